// File: rtl/dcache_pkg.sv
// Shared types and field-width helpers for the direct-mapped write-through data cache.
package dcache_pkg;

   localparam logic [1:0] W_BYTE = 2'b00;
   localparam logic [1:0] W_HALF = 2'b01;
   localparam logic [1:0] W_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2
   } state_t;

   localparam int INDEX_BITS_DEF = 6;
   localparam int LINE_WORDS_DEF = 4;

   function automatic int woff_bits(input int line_words);
      return (line_words > 1) ? $clog2(line_words) : 0;
   endfunction

   function automatic int tag_bits(input int index_bits, input int line_words);
      return 32 - 2 - woff_bits(line_words) - index_bits;
   endfunction

endpackage

// File: rtl/dcache_if.sv
// Request/acknowledge backing-memory bus between the cache (master) and memory (slave).
interface dcache_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        ack;
   logic [31:0] rdata;

   modport master (output req, we, addr, wdata, wstrb, input ack, rdata);
   modport slave  (input req, we, addr, wdata, wstrb, output ack, rdata);
endinterface

// File: rtl/dcache_align.sv
// Combinational lane logic: load extract with sign/zero extension, store replication and byte strobes.
module dcache_align
   import dcache_pkg::*;
(
   input  logic [1:0]  width,
   input  logic        ext,
   input  logic [1:0]  byte_off,
   input  logic [31:0] rd_word,
   input  logic [31:0] st_in,
   output logic [31:0] ld_data,
   output logic [31:0] st_data,
   output logic [3:0]  st_strb
);
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      ld_byte = rd_word[7:0];
      case (byte_off)
         2'd1:    ld_byte = rd_word[15:8];
         2'd2:    ld_byte = rd_word[23:16];
         2'd3:    ld_byte = rd_word[31:24];
         default: ld_byte = rd_word[7:0];
      endcase
      ld_half = byte_off[1] ? rd_word[31:16] : rd_word[15:0];

      ld_data = rd_word;
      st_data = st_in;
      st_strb = 4'b1111;
      // Misaligned half/word accesses simply drop the low offset bits.
      case (width)
         W_BYTE: begin
            ld_data = {{24{ext & ld_byte[7]}}, ld_byte};
            st_data = {4{st_in[7:0]}};
            st_strb = 4'b0001 << byte_off;
         end
         W_HALF: begin
            ld_data = {{16{ext & ld_half[15]}}, ld_half};
            st_data = {2{st_in[15:0]}};
            st_strb = byte_off[1] ? 4'b1100 : 4'b0011;
         end
         W_WORD, 2'b11: begin
            ld_data = rd_word;
            st_data = st_in;
            st_strb = 4'b1111;
         end
         default: begin
            ld_data = rd_word;
            st_data = st_in;
            st_strb = 4'b1111;
         end
      endcase
   end
endmodule

// File: rtl/dcache_dm.sv
// Direct-mapped write-through data cache with line fill on read miss and no-allocate stores.
//
// state | meaning
// IDLE  | valid=1, a request is sampled every edge; flush clears all line valid bits
// FILL  | read miss, fetching the line word by word from backing memory
// WRITE | store written through to backing memory, waiting for ack
module dcache_dm
   import dcache_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE  = 32'h1001_0000,
   parameter int          INDEX_BITS = INDEX_BITS_DEF,
   parameter int          LINE_WORDS = LINE_WORDS_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        r_ena,
   input  logic        w_ena,
   input  logic [31:0] addr,
   input  logic [1:0]  width,
   input  logic        ext,
   input  logic [31:0] data_in,
   input  logic        flush,
   output logic        valid,
   output logic [31:0] data_out,
   dcache_if.master    mem
);
   localparam int          WOFF_BITS = woff_bits(LINE_WORDS);
   localparam int          WI_W      = (WOFF_BITS > 0) ? WOFF_BITS : 1;
   localparam int          TAG_BITS  = tag_bits(INDEX_BITS, LINE_WORDS);
   localparam int          TAG_LSB   = 32 - TAG_BITS;
   localparam int          LINES     = 1 << INDEX_BITS;
   localparam int          RA_W      = INDEX_BITS + WOFF_BITS;
   localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS * 4 - 1);

   state_t                state_q, state_d;
   logic [WI_W-1:0]       words_left_q, words_left_d;
   logic [LINES-1:0]      line_vld_q, line_vld_d;
   logic [31:0]           data_out_q, data_out_d;
   logic                  mem_req_q, mem_req_d;
   logic                  mem_we_q, mem_we_d;
   logic [31:0]           mem_addr_q, mem_addr_d;
   logic [31:0]           mem_wdata_q, mem_wdata_d;
   logic [3:0]            mem_wstrb_q, mem_wstrb_d;

   logic [31:0]           data_mem [LINES*LINE_WORDS];
   logic [TAG_BITS-1:0]   tag_mem  [LINES];

   logic [31:0]           off;
   logic [31:0]           line_base;
   logic [TAG_BITS-1:0]   req_tag;
   logic [INDEX_BITS-1:0] req_idx;
   logic [WI_W-1:0]       req_word;
   logic [WI_W-1:0]       fill_word;
   logic [RA_W-1:0]       rd_addr;
   logic [RA_W-1:0]       fill_addr;
   logic                  hit;
   logic [31:0]           rd_word;
   logic [31:0]           ld_data;
   logic [31:0]           st_data;
   logic [3:0]            st_strb;

   logic [3:0]            ram_we;
   logic [RA_W-1:0]       ram_waddr;
   logic [31:0]           ram_wdata;
   logic                  tag_we;

   assign off       = addr - ADDR_BASE;
   assign line_base = ADDR_BASE + (off & ~LINE_MASK);
   assign req_tag   = off[31:TAG_LSB];
   assign req_idx   = off[TAG_LSB-1 -: INDEX_BITS];

   generate
      if (WOFF_BITS > 0) begin : g_word
         assign req_word = off[2 +: WOFF_BITS];
      end else begin : g_noword
         assign req_word = '0;
      end
   endgenerate

   // Words are fetched in order from word 0, so the word in flight follows from the countdown.
   assign fill_word = WI_W'(LINE_WORDS - 1) - words_left_q;
   assign rd_addr   = (RA_W'(req_idx) << WOFF_BITS) | RA_W'(req_word);
   assign fill_addr = (RA_W'(req_idx) << WOFF_BITS) | RA_W'(fill_word);

   assign hit     = line_vld_q[req_idx] & (tag_mem[req_idx] == req_tag);
   assign rd_word = (state_q == FILL && fill_word == req_word) ? mem.rdata : data_mem[rd_addr];

   dcache_align u_align (
      .width    (width),
      .ext      (ext),
      .byte_off (off[1:0]),
      .rd_word  (rd_word),
      .st_in    (data_in),
      .ld_data  (ld_data),
      .st_data  (st_data),
      .st_strb  (st_strb)
   );

   always_comb begin
      state_d      = state_q;
      words_left_d = words_left_q;
      line_vld_d   = line_vld_q;
      data_out_d   = data_out_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_wstrb_d  = mem_wstrb_q;
      ram_we       = 4'b0000;
      ram_waddr    = rd_addr;
      ram_wdata    = st_data;
      tag_we       = 1'b0;

      case (state_q)
         IDLE: begin
            if (flush) begin
               line_vld_d = '0;
            end else if (w_ena) begin
               state_d     = WRITE;
               mem_req_d   = 1'b1;
               mem_we_d    = 1'b1;
               mem_addr_d  = {addr[31:2], 2'b00};
               mem_wdata_d = st_data;
               mem_wstrb_d = st_strb;
               if (hit) ram_we = st_strb;
            end else if (r_ena) begin
               if (hit) begin
                  data_out_d = ld_data;
               end else begin
                  state_d      = FILL;
                  mem_req_d    = 1'b1;
                  mem_we_d     = 1'b0;
                  mem_addr_d   = line_base;
                  words_left_d = WI_W'(LINE_WORDS - 1);
               end
            end
         end
         FILL: begin
            if (mem.ack) begin
               ram_we    = 4'b1111;
               ram_waddr = fill_addr;
               ram_wdata = mem.rdata;
               if (words_left_q == '0) begin
                  state_d             = IDLE;
                  mem_req_d           = 1'b0;
                  tag_we              = 1'b1;
                  line_vld_d[req_idx] = 1'b1;
                  data_out_d          = ld_data;
               end else begin
                  words_left_d = words_left_q - WI_W'(1);
                  mem_addr_d   = mem_addr_q + 32'd4;
               end
            end
         end
         WRITE: begin
            if (mem.ack) begin
               state_d   = IDLE;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         words_left_q <= '0;
         line_vld_q   <= '0;
         data_out_q   <= '0;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_wstrb_q  <= '0;
      end else begin
         state_q      <= state_d;
         words_left_q <= words_left_d;
         line_vld_q   <= line_vld_d;
         data_out_q   <= data_out_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_wstrb_q  <= mem_wstrb_d;
      end
   end

   // Arrays carry no reset; a line is only trusted once its valid bit is set.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (ram_we[b]) data_mem[ram_waddr][8*b +: 8] <= ram_wdata[8*b +: 8];
      end
      if (tag_we) tag_mem[req_idx] <= req_tag;
   end

   assign valid     = (state_q == IDLE);
   assign data_out  = data_out_q;
   assign mem.req   = mem_req_q;
   assign mem.we    = mem_we_q;
   assign mem.addr  = mem_addr_q;
   assign mem.wdata = mem_wdata_q;
   assign mem.wstrb = mem_wstrb_q;

endmodule

// File: tb/tb_dcache_dm.sv
// Directed bench for dcache_dm with a behavioural backing memory of programmable ack delay.
module tb_dcache_dm;
   import dcache_pkg::*;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } tr_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        r_ena = 1'b0;
   logic        w_ena = 1'b0;
   logic [31:0] addr = 32'h0;
   logic [1:0]  width = 2'b00;
   logic        ext = 1'b0;
   logic [31:0] data_in = 32'h0;
   logic        flush = 1'b0;
   logic        valid;
   logic [31:0] data_out;

   int          checks = 0;
   int          errors = 0;
   int          ack_dly = 2;
   int          ack_cnt = 0;
   tr_t         log_q[$];
   logic [31:0] mem_m [logic [31:0]];

   dcache_if mif ();

   dcache_dm #(
      .ADDR_BASE  (32'h1001_0000),
      .INDEX_BITS (6),
      .LINE_WORDS (4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .r_ena    (r_ena),
      .w_ena    (w_ena),
      .addr     (addr),
      .width    (width),
      .ext      (ext),
      .data_in  (data_in),
      .flush    (flush),
      .valid    (valid),
      .data_out (data_out),
      .mem      (mif)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rd_model(input logic [31:0] a);
      if (mem_m.exists(a)) return mem_m[a];
      return a;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Memory responder: ack arrives ack_dly cycles after a request is first seen.
   initial begin
      logic [31:0] w;
      mif.ack   = 1'b0;
      mif.rdata = 32'h0;
      forever begin
         @(negedge clk);
         if (!rst_n || !mif.req) begin
            mif.ack = 1'b0;
            ack_cnt = 0;
         end else if (ack_cnt >= ack_dly) begin
            mif.ack = 1'b1;
            ack_cnt = 0;
            if (mif.we) begin
               w = rd_model(mif.addr);
               for (int b = 0; b < 4; b++)
                  if (mif.wstrb[b]) w[8*b +: 8] = mif.wdata[8*b +: 8];
               mem_m[mif.addr] = w;
            end else begin
               mif.rdata = rd_model(mif.addr);
            end
            log_q.push_back('{mif.we, mif.addr, mif.wdata, mif.wstrb});
         end else begin
            mif.ack = 1'b0;
            ack_cnt++;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic issue(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [1:0] w, input bit e, input logic [31:0] d);
      @(posedge clk); #1;
      r_ena = rd; w_ena = wr; addr = a; width = w; ext = e; data_in = d;
      @(posedge clk); #1;
      r_ena = 1'b0; w_ena = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!valid && cyc < 500) begin
         @(posedge clk); #1;
         cyc++;
      end
      check("valid timeout", 32'(valid), 32'h1);
   endtask

   task automatic ld(input string tag, input logic [31:0] a, input logic [1:0] w, input bit e,
                     input logic [31:0] exp_d, input int exp_reads);
      int cyc;
      log_q.delete();
      issue(1'b1, 1'b0, a, w, e, 32'h0);
      wait_done(cyc);
      check({tag, " data"}, data_out, exp_d);
      check({tag, " cycles"}, 32'(cyc), 32'(exp_reads * (ack_dly + 1)));
      check({tag, " reads"}, 32'(log_q.size()), 32'(exp_reads));
      for (int i = 0; i < log_q.size(); i++) begin
         check({tag, " rd addr"}, log_q[i].addr, (a & ~32'hF) + 32'(4 * i));
         check({tag, " rd we"}, 32'(log_q[i].we), 32'h0);
      end
   endtask

   task automatic st(input string tag, input bit also_rd, input logic [31:0] a, input logic [1:0] w,
                     input logic [31:0] d, input logic [31:0] exp_wdata, input logic [3:0] exp_strb);
      int  cyc;
      tr_t t;
      log_q.delete();
      issue(also_rd, 1'b1, a, w, 1'b0, d);
      wait_done(cyc);
      check({tag, " cycles"}, 32'(cyc), 32'(ack_dly + 1));
      check({tag, " writes"}, 32'(log_q.size()), 32'h1);
      t = '0;
      if (log_q.size() > 0) t = log_q[0];
      check({tag, " we"}, 32'(t.we), 32'h1);
      check({tag, " addr"}, t.addr, {a[31:2], 2'b00});
      check({tag, " wdata"}, t.wdata, exp_wdata);
      check({tag, " wstrb"}, 32'(t.wstrb), 32'(exp_strb));
   endtask

   initial begin
      int guard;
      int cyc;
      mem_m[32'h1001_0000] = 32'hDEAD_BEEF;

      repeat (3) @(posedge clk);
      #1;
      check("rst valid", 32'(valid), 32'h1);
      check("rst data_out", data_out, 32'h0);
      check("rst req", 32'(mif.req), 32'h0);
      check("rst we", 32'(mif.we), 32'h0);
      check("rst addr", mif.addr, 32'h0);
      check("rst wdata", mif.wdata, 32'h0);
      check("rst wstrb", 32'(mif.wstrb), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      ld("miss0", 32'h1001_0000, W_WORD, 1'b0, 32'hDEAD_BEEF, 4);
      ld("hit0", 32'h1001_0000, W_WORD, 1'b0, 32'hDEAD_BEEF, 0);
      ld("lb sx", 32'h1001_0003, W_BYTE, 1'b1, 32'hFFFF_FFDE, 0);
      ld("lb zx", 32'h1001_0003, W_BYTE, 1'b0, 32'h0000_00DE, 0);
      ld("lh sx", 32'h1001_0002, W_HALF, 1'b1, 32'hFFFF_DEAD, 0);
      ld("lb1 sx", 32'h1001_0001, W_BYTE, 1'b1, 32'hFFFF_FFBE, 0);
      ld("lw1", 32'h1001_0004, W_WORD, 1'b0, 32'h1001_0004, 0);

      st("sh hit", 1'b0, 32'h1001_0002, W_HALF, 32'h0000_1234, 32'h1234_1234, 4'b1100);
      ld("lw merged", 32'h1001_0000, W_WORD, 1'b0, 32'h1234_BEEF, 0);
      st("sb hit", 1'b0, 32'h1001_0005, W_BYTE, 32'h0000_00AB, 32'hABAB_ABAB, 4'b0010);
      ld("lw1 merged", 32'h1001_0004, W_WORD, 1'b0, 32'h1001_AB04, 0);

      st("sw miss", 1'b0, 32'h1001_0400, W_WORD, 32'hCAFE_F00D, 32'hCAFE_F00D, 4'b1111);
      ld("no alloc", 32'h1001_0000, W_WORD, 1'b0, 32'h1234_BEEF, 0);
      ld("fill 400", 32'h1001_0400, W_WORD, 1'b0, 32'hCAFE_F00D, 4);

      ld("alt a", 32'h1001_0000, W_WORD, 1'b0, 32'h1234_BEEF, 4);
      ld("alt b", 32'h1001_0400, W_WORD, 1'b0, 32'hCAFE_F00D, 4);
      ld("alt a2", 32'h1001_0000, W_WORD, 1'b0, 32'h1234_BEEF, 4);
      ld("lw1 refill", 32'h1001_0004, W_WORD, 1'b0, 32'h1001_AB04, 0);

      // flush wins over a same-cycle load that would otherwise miss
      @(posedge clk); #1;
      flush = 1'b1; r_ena = 1'b1; addr = 32'h1001_0400; width = W_WORD;
      @(posedge clk); #1;
      flush = 1'b0; r_ena = 1'b0;
      check("flush valid", 32'(valid), 32'h1);
      check("flush req", 32'(mif.req), 32'h0);
      check("flush data_out", data_out, 32'h1001_AB04);
      @(posedge clk); #1;
      check("flush req later", 32'(mif.req), 32'h0);
      ld("post flush", 32'h1001_0000, W_WORD, 1'b0, 32'h1234_BEEF, 4);

      // flush while busy is ignored
      issue(1'b1, 1'b0, 32'h1001_0030, W_WORD, 1'b0, 32'h0);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      wait_done(cyc);
      check("busy flush data", data_out, 32'h1001_0030);
      ld("busy flush hit", 32'h1001_0030, W_WORD, 1'b0, 32'h1001_0030, 0);

      // reset during the second fill word
      log_q.delete();
      issue(1'b1, 1'b0, 32'h1001_0020, W_WORD, 1'b0, 32'h0);
      guard = 0;
      while (log_q.size() < 1 && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      check("mid fill first ack", 32'(log_q.size()), 32'h1);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("mid rst req", 32'(mif.req), 32'h0);
      check("mid rst valid", 32'(valid), 32'h1);
      check("mid rst data_out", data_out, 32'h0);
      @(negedge clk); #2;
      rst_n = 1'b1;
      ld("after rst", 32'h1001_0020, W_WORD, 1'b0, 32'h1001_0020, 4);
      ld("rst cleared", 32'h1001_0000, W_WORD, 1'b0, 32'h1234_BEEF, 4);

      // zero-delay acknowledge
      ack_dly = 0;
      ld("d0 fill", 32'h1001_0104, W_WORD, 1'b0, 32'h1001_0104, 4);
      st("d0 sh", 1'b0, 32'h1001_0100, W_HALF, 32'h0000_8765, 32'h8765_8765, 4'b0011);
      ld("d0 lh sx", 32'h1001_0100, W_HALF, 1'b1, 32'hFFFF_8765, 0);
      ld("d0 lh zx", 32'h1001_0100, W_HALF, 1'b0, 32'h0000_8765, 0);
      ld("d0 w11 misal", 32'h1001_0102, 2'b11, 1'b0, 32'h1001_8765, 0);
      st("d0 both", 1'b1, 32'h1001_0108, W_WORD, 32'h55AA_55AA, 32'h55AA_55AA, 4'b1111);
      ld("d0 both rd", 32'h1001_0108, W_WORD, 1'b0, 32'h55AA_55AA, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
